// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared, fixed-latency memory.
// Data requests normally win; a bounded starvation counter guarantees fetch progress.
module mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_type,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_type,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  localparam logic [2:0] LAT_C      = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_C   = 4'(STARVE_MAX);
  localparam logic [2:0] FETCH_TYPE = 3'b010;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [2:0]  lat_q, lat_d;
  logic        wr_q, wr_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  mem_type_q, mem_type_d;
  logic        grant_if, grant_dm;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    lat_d       = lat_q;
    wr_d        = wr_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_type_d  = mem_type_q;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The ack cycle is spent idle: the requester still holds req until it sees ack.
        if (!(if_ack_q || dm_ack_q)) begin
          if (if_req && ((starve_q == STARVE_C) || !dm_req)) begin
            grant_if = 1'b1;
          end else if (dm_req) begin
            grant_dm = 1'b1;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (lat_q == LAT_C) begin
          state_d = IDLE;
          lat_d   = 3'd0;
          if (state_q == BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_ack_d = 1'b1;
            if (!wr_q) begin
              dm_rdata_d = mem_rdata;
            end
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_if) begin
      state_d     = BUSY_IF;
      lat_d       = 3'd1;
      wr_d        = 1'b0;
      mem_en_d    = 1'b1;
      mem_addr_d  = if_addr;
      mem_wdata_d = 32'd0;
      mem_type_d  = FETCH_TYPE;
    end else if (grant_dm) begin
      state_d     = BUSY_DM;
      lat_d       = 3'd1;
      wr_d        = dm_we;
      mem_en_d    = 1'b1;
      mem_we_d    = dm_we;
      mem_addr_d  = dm_addr;
      mem_wdata_d = dm_wdata;
      mem_type_d  = dm_type;
    end

    // Counts data grants that overtook a waiting fetch.
    if (grant_if || !if_req) begin
      starve_d = 4'd0;
    end else if (grant_dm && (starve_q != STARVE_C)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      lat_q       <= 3'd0;
      wr_q        <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_type_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      lat_q       <= lat_d;
      wr_q        <= wr_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_type_q  <= mem_type_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_type  = mem_type_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner-case sequences, latency sweep
// instances and a randomized run checked against a transaction-timing reference model.
module tb_mem_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [2:0]  dm_type = '0;
  logic        if_ack, dm_ack, mem_en, mem_we, stall_if, stall_mem;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_type;

  mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_type(dm_type),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_type(mem_type),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  // Latency-sweep instances (fetch port only).
  logic        l1_req = 1'b0, l7_req = 1'b0;
  logic        l1_ack, l7_ack, l1_dack, l7_dack, l1_en, l7_en, l1_we, l7_we, l1_sif, l7_sif, l1_sdm, l7_sdm;
  logic [31:0] l1_rd, l7_rd, l1_drd, l7_drd, l1_ma, l7_ma, l1_mw, l7_mw;
  logic [2:0]  l1_mt, l7_mt;

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) u_l1 (
    .clk(clk), .reset(reset), .if_req(l1_req), .if_addr(32'h0000_0040), .if_ack(l1_ack), .if_rdata(l1_rd),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'd0), .dm_wdata(32'd0), .dm_type(3'd0),
    .dm_ack(l1_dack), .dm_rdata(l1_drd), .mem_en(l1_en), .mem_we(l1_we), .mem_addr(l1_ma),
    .mem_wdata(l1_mw), .mem_type(l1_mt), .mem_rdata(32'hCAFE_0001), .stall_if(l1_sif), .stall_mem(l1_sdm)
  );

  mem_arbiter #(.MEM_LAT(7), .STARVE_MAX(SMAX)) u_l7 (
    .clk(clk), .reset(reset), .if_req(l7_req), .if_addr(32'h0000_0080), .if_ack(l7_ack), .if_rdata(l7_rd),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'd0), .dm_wdata(32'd0), .dm_type(3'd0),
    .dm_ack(l7_dack), .dm_rdata(l7_drd), .mem_en(l7_en), .mem_we(l7_we), .mem_addr(l7_ma),
    .mem_wdata(l7_mw), .mem_type(l7_mt), .mem_rdata(32'hCAFE_0007), .stall_if(l7_sif), .stall_mem(l7_sdm)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Shared memory behind the DUT: returns the word in the cycle MEM_LAT-1 after mem_en.
  bit          mem_model_on = 1'b0;
  int          en_c = -100;
  logic [31:0] phys [logic [31:0]];
  logic [31:0] refm [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rd_phys(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_word(a);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    cyc++;
    #1;
    if (mem_model_on) begin
      if (mem_en) begin
        en_c = cyc;
        if (mem_we) phys[mem_addr] = mem_wdata;
      end
      if (cyc == en_c + LAT - 1) mem_rdata = rd_phys(mem_addr);
      else mem_rdata = $urandom;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_if_ack"}, {31'd0, if_ack}, 32'd0);
    chk({tag, "_dm_ack"}, {31'd0, dm_ack}, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    chk({tag, "_mem_en_we"}, {30'd0, mem_en, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_type"}, {29'd0, mem_type}, 32'd0);
    chk({tag, "_stalls"}, {30'd0, stall_if, stall_mem}, 32'd0);
  endtask

  task automatic do_reset(input bit check);
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; l1_req = 1'b0; l7_req = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    if (check) check_zero("reset");
    next_cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    logic ir; logic [31:0] ia; logic dr; logic dw; logic [31:0] da; logic [31:0] dd; logic [2:0] dt; logic [31:0] mr;
    logic e_ia; logic e_da; logic e_en; logic e_we; logic [31:0] e_ma; logic [31:0] e_mw; logic [2:0] e_mt;
    logic e_sif; logic e_sdm; logic [31:0] e_ird; logic [31:0] e_drd;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] dd, input logic [2:0] dt, input logic [31:0] mr,
                              input logic e_ia, input logic e_da, input logic e_en, input logic e_we,
                              input logic [31:0] e_ma, input logic [31:0] e_mw, input logic [2:0] e_mt,
                              input logic e_sif, input logic e_sdm, input logic [31:0] e_ird, input logic [31:0] e_drd);
    vec_t v;
    v = '{ir, ia, dr, dw, da, dd, dt, mr, e_ia, e_da, e_en, e_we, e_ma, e_mw, e_mt, e_sif, e_sdm, e_ird, e_drd};
    return v;
  endfunction

  // Reference model: one access at a time, timed purely from grant timestamps.
  int          nf, pk, en_m, ack_m, starve;
  logic        e_we, prev_en, obs_if_ack, obs_dm_ack;
  logic [31:0] e_addr, e_wd, e_rd, h_if, h_dm;
  logic [2:0]  e_type;

  task automatic model_step();
    logic x_ia, x_da, x_en, fetch, granted;
    x_ia = (pk == 1) && (cyc == ack_m);
    x_da = (pk == 2) && (cyc == ack_m);
    x_en = (pk != 0) && (cyc == en_m);
    chk("rnd_if_ack", {31'd0, if_ack}, {31'd0, x_ia});
    chk("rnd_dm_ack", {31'd0, dm_ack}, {31'd0, x_da});
    chk("rnd_mem_en", {31'd0, mem_en}, {31'd0, x_en});
    if (x_en) begin
      chk("rnd_mem_addr", mem_addr, e_addr);
      chk("rnd_mem_we", {31'd0, mem_we}, {31'd0, e_we});
      if (e_we) begin
        chk("rnd_mem_wdata", mem_wdata, e_wd);
        chk("rnd_mem_type", {29'd0, mem_type}, {29'd0, e_type});
      end
    end
    if (x_ia) begin h_if = e_rd; pk = 0; end
    if (x_da) begin if (!e_we) h_dm = e_rd; pk = 0; end
    chk("rnd_if_rdata", if_rdata, h_if);
    chk("rnd_dm_rdata", dm_rdata, h_dm);
    chk("rnd_stall_if", {31'd0, stall_if}, {31'd0, if_req && !x_ia});
    chk("rnd_stall_mem", {31'd0, stall_mem}, {31'd0, dm_req && !x_da});
    chk("rnd_ack_onehot", {31'd0, if_ack & dm_ack}, 32'd0);
    chk("rnd_en_back2back", {31'd0, prev_en & mem_en}, 32'd0);
    prev_en = mem_en; obs_if_ack = if_ack; obs_dm_ack = dm_ack;

    granted = (cyc >= nf) && (if_req || dm_req);
    fetch   = if_req && ((starve == SMAX) || !dm_req);
    if (granted) begin
      en_m = cyc + 1; ack_m = cyc + LAT + 1; nf = cyc + LAT + 2;
      if (fetch) begin
        pk = 1; e_addr = if_addr; e_we = 1'b0; e_rd = rd_ref(if_addr);
      end else begin
        pk = 2; e_addr = dm_addr; e_we = dm_we; e_wd = dm_wdata; e_type = dm_type;
        if (dm_we) refm[dm_addr] = dm_wdata;
        else e_rd = rd_ref(dm_addr);
      end
    end
    if ((granted && fetch) || !if_req) starve = 0;
    else if (granted) starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h0000_1000 + 32'($urandom_range(0, 7) << 2);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[$];
    logic [31:0] grants[$];
    logic [31:0] exp_g;
    int n_en, n_dm, n_if, lat1, lat7, g, gi;
    bit seen;

    // ---------------- directed vector table ----------------
    tv.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0,              0, 0, 1, 0, 32'h100, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 32'h0050_0093,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 32'hBAD0_BAD0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0050_0093, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0050_0093, 0));
    tv.push_back(mk(0, 0, 1, 1, 32'h2004, 32'hDEAD_BEEF, 3'b010, 0,           0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0050_0093, 0));
    tv.push_back(mk(0, 0, 1, 1, 32'h2004, 32'hDEAD_BEEF, 3'b010, 32'h1111_1111, 0, 0, 1, 1, 32'h2004, 32'hDEAD_BEEF, 3'b010, 0, 1, 32'h0050_0093, 0));
    tv.push_back(mk(0, 0, 1, 1, 32'h2004, 32'hDEAD_BEEF, 3'b010, 32'h2222_2222, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0050_0093, 0));
    tv.push_back(mk(0, 0, 1, 1, 32'h2004, 32'hDEAD_BEEF, 3'b010, 32'h3333_3333, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0050_0093, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0050_0093, 0));
    tv.push_back(mk(1, 32'h200, 1, 0, 32'h300, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0050_0093, 0));
    tv.push_back(mk(1, 32'h200, 1, 0, 32'h300, 0, 0, 0,        0, 0, 1, 0, 32'h300, 0, 0, 1, 1, 32'h0050_0093, 0));
    tv.push_back(mk(1, 32'h200, 1, 0, 32'h300, 0, 0, 32'hA5A5_0300, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0050_0093, 0));
    tv.push_back(mk(1, 32'h200, 1, 0, 32'h300, 0, 0, 0,        0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0050_0093, 32'hA5A5_0300));
    tv.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0050_0093, 32'hA5A5_0300));
    tv.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 0,              0, 0, 1, 0, 32'h200, 0, 0, 1, 0, 32'h0050_0093, 32'hA5A5_0300));
    tv.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 32'h0F0F_0200,  0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0050_0093, 32'hA5A5_0300));
    tv.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0F0F_0200, 32'hA5A5_0300));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0F0F_0200, 32'hA5A5_0300));

    next_cycle();
    do_reset(1'b1);
    mem_model_on = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      if_req = tv[i].ir; if_addr = tv[i].ia; dm_req = tv[i].dr; dm_we = tv[i].dw;
      dm_addr = tv[i].da; dm_wdata = tv[i].dd; dm_type = tv[i].dt; mem_rdata = tv[i].mr;
      @(negedge clk);
      chk($sformatf("row%0d_if_ack", i), {31'd0, if_ack}, {31'd0, tv[i].e_ia});
      chk($sformatf("row%0d_dm_ack", i), {31'd0, dm_ack}, {31'd0, tv[i].e_da});
      chk($sformatf("row%0d_mem_en", i), {31'd0, mem_en}, {31'd0, tv[i].e_en});
      chk($sformatf("row%0d_mem_we", i), {31'd0, mem_we}, {31'd0, tv[i].e_we});
      if (tv[i].e_en) chk($sformatf("row%0d_mem_addr", i), mem_addr, tv[i].e_ma);
      if (tv[i].e_en && tv[i].e_we) begin
        chk($sformatf("row%0d_mem_wdata", i), mem_wdata, tv[i].e_mw);
        chk($sformatf("row%0d_mem_type", i), {29'd0, mem_type}, {29'd0, tv[i].e_mt});
      end
      chk($sformatf("row%0d_stall_if", i), {31'd0, stall_if}, {31'd0, tv[i].e_sif});
      chk($sformatf("row%0d_stall_mem", i), {31'd0, stall_mem}, {31'd0, tv[i].e_sdm});
      chk($sformatf("row%0d_if_rdata", i), if_rdata, tv[i].e_ird);
      chk($sformatf("row%0d_dm_rdata", i), dm_rdata, tv[i].e_drd);
      next_cycle();
    end

    // ---------------- starvation: D D D D F D D D D F ----------------
    do_reset(1'b0);
    mem_model_on = 1'b1; en_c = -100; phys.delete();
    if_req = 1'b1; if_addr = 32'h400; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    for (int i = 0; i < 200 && grants.size() < 10; i++) begin
      @(negedge clk);
      if (mem_en) grants.push_back(mem_addr);
      next_cycle();
    end
    chk("starve_grant_count", 32'(grants.size()), 32'd10);
    for (int i = 0; i < grants.size(); i++) begin
      exp_g = ((i % 5) == 4) ? 32'h400 : 32'h500;
      chk($sformatf("starve_grant%0d", i), grants[i], exp_g);
    end

    // ---------------- withdrawn request, reset mid-access ----------------
    do_reset(1'b0);
    en_c = -100;
    n_en = 0; n_dm = 0; n_if = 0; seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if_req = !seen; if_addr = 32'h600; dm_req = (i == 1); dm_we = 1'b0; dm_addr = 32'h700;
      @(negedge clk);
      if (mem_en) n_en++;
      if (dm_ack) n_dm++;
      if (if_ack) begin n_if++; seen = 1'b1; end
      next_cycle();
    end
    chk("withdraw_mem_en_count", 32'(n_en), 32'd1);
    chk("withdraw_dm_ack_count", 32'(n_dm), 32'd0);
    chk("withdraw_if_ack_count", 32'(n_if), 32'd1);
    chk("withdraw_if_rdata", if_rdata, init_word(32'h600));

    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dm_req = !seen; dm_we = 1'b0; dm_addr = 32'h704;
      @(negedge clk);
      if (dm_ack) seen = 1'b1;
      next_cycle();
    end
    chk("load_dm_rdata", dm_rdata, init_word(32'h704));

    dm_req = 1'b1; dm_addr = 32'h708;
    @(negedge clk); chk("rstmid_grant_no_en", {31'd0, mem_en}, 32'd0);
    next_cycle();
    @(negedge clk); chk("rstmid_mem_en", {31'd0, mem_en}, 32'd1);
    next_cycle();
    reset = 1'b1; dm_req = 1'b0;
    @(negedge clk);
    next_cycle();
    reset = 1'b0;
    @(negedge clk); check_zero("rstmid");
    next_cycle();
    n_dm = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dm_ack || mem_en) n_dm++;
      next_cycle();
    end
    chk("rstmid_no_late_ack", 32'(n_dm), 32'd0);

    if_req = 1'b1; if_addr = 32'h60C; g = cyc; gi = -1;
    for (int i = 0; i < 12 && gi < 0; i++) begin
      @(negedge clk);
      if (if_ack) gi = cyc - g;
      next_cycle();
      if (gi >= 0) if_req = 1'b0;
    end
    chk("after_reset_fetch_latency", 32'(gi), 32'(LAT + 1));
    chk("after_reset_fetch_rdata", if_rdata, init_word(32'h60C));
    if_req = 1'b0;

    // ---------------- latency sweep MEM_LAT=1 and 7 ----------------
    do_reset(1'b0);
    l1_req = 1'b1; l7_req = 1'b1; g = cyc; lat1 = -1; lat7 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lat1 < 0) begin
        if (l1_ack) lat1 = cyc - g;
        chk("sweep1_stall", {31'd0, l1_sif}, {31'd0, !l1_ack});
      end
      if (lat7 < 0) begin
        if (l7_ack) lat7 = cyc - g;
        chk("sweep7_stall", {31'd0, l7_sif}, {31'd0, !l7_ack});
      end
      next_cycle();
      if (lat1 >= 0) l1_req = 1'b0;
      if (lat7 >= 0) l7_req = 1'b0;
    end
    chk("sweep1_latency", 32'(lat1), 32'd2);
    chk("sweep7_latency", 32'(lat7), 32'd8);
    chk("sweep1_rdata", l1_rd, 32'hCAFE_0001);
    chk("sweep7_rdata", l7_rd, 32'hCAFE_0007);

    // ---------------- randomized run against the reference model ----------------
    do_reset(1'b0);
    en_c = -100; phys.delete(); refm.delete();
    nf = 0; pk = 0; en_m = -1; ack_m = -1; starve = 0;
    e_we = 1'b0; prev_en = 1'b0; obs_if_ack = 1'b0; obs_dm_ack = 1'b0;
    e_addr = '0; e_wd = '0; e_rd = '0; e_type = '0; h_if = '0; h_dm = '0;
    for (int n = 0; n < 800; n++) begin
      if (if_req && obs_if_ack) if_req = 1'b0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = rand_addr();
      end
      if (dm_req && obs_dm_ack) dm_req = 1'b0;
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_addr = rand_addr();
        dm_wdata = $urandom; dm_type = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      model_step();
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
